// File: rtl/pong_input_pkg.sv
// Shared types and helpers for the Pong pushbutton input path.
package pong_input_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONFIRM_HI,
        HELD_DELAY,
        HELD_REPEAT,
        CONFIRM_LO
    } btn_state_t;

    // Width needed to count up to (largest cycle parameter - 1).
    function automatic int unsigned cnt_width(input int unsigned deb,
                                              input int unsigned dly,
                                              input int unsigned rate);
        int unsigned m;
        m = deb;
        if (dly > m) m = dly;
        if (rate > m) m = rate;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, debounce/auto-repeat FSM, shared counter.
module btn_channel
    import pong_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC     = 250000,
    parameter int unsigned REPEAT_DELAY_CYC = 25000000,
    parameter int unsigned REPEAT_RATE_CYC  = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic step_o
);

    localparam int unsigned CntW = cnt_width(DEBOUNCE_CYC, REPEAT_DELAY_CYC, REPEAT_RATE_CYC);
    localparam logic [CntW-1:0] DebLast   = CntW'(DEBOUNCE_CYC - 1);
    localparam logic [CntW-1:0] DelayLast = CntW'(REPEAT_DELAY_CYC - 1);
    localparam logic [CntW-1:0] RateLast  = CntW'(REPEAT_RATE_CYC - 1);

    logic            sync1_q, sync2_q;
    btn_state_t      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            cnt_clr;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            step_q, step_d;

    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b0;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        step_d    = 1'b0;
        if (!en_i) begin
            state_d = IDLE;
            level_d = 1'b0;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // Held at zero so the counter cannot run free while idle.
                    cnt_clr = 1'b1;
                    if (sync2_q) state_d = CONFIRM_HI;
                end
                CONFIRM_HI: begin
                    if (!sync2_q) begin
                        state_d = IDLE;
                    end else if (cnt_q == DebLast) begin
                        state_d = HELD_DELAY;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        step_d  = 1'b1;
                    end
                end
                HELD_DELAY: begin
                    if (!sync2_q) begin
                        state_d = CONFIRM_LO;
                    end else if (cnt_q == DelayLast) begin
                        state_d = HELD_REPEAT;
                        step_d  = 1'b1;
                    end
                end
                HELD_REPEAT: begin
                    if (!sync2_q) begin
                        state_d = CONFIRM_LO;
                    end else if (cnt_q == RateLast) begin
                        step_d  = 1'b1;
                        cnt_clr = 1'b1;
                    end
                end
                CONFIRM_LO: begin
                    if (sync2_q) begin
                        state_d = HELD_DELAY;
                    end else if (cnt_q == DebLast) begin
                        state_d   = IDLE;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    level_d = 1'b0;
                end
            endcase
        end
        cnt_d = (cnt_clr || (state_d != state_q)) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            sync1_q   <= raw_i;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            step_q    <= step_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign step_o    = step_q;

endmodule

// File: rtl/paddle_btn_ctrl.sv
// Pong paddle/serve button controller: NUM_BTN independent debounce/repeat channels.
module paddle_btn_ctrl
    import pong_input_pkg::*;
#(
    parameter int unsigned NUM_BTN          = 4,
    parameter int unsigned DEBOUNCE_CYC     = 250000,
    parameter int unsigned REPEAT_DELAY_CYC = 25000000,
    parameter int unsigned REPEAT_RATE_CYC  = 5000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_step
);

    // One register stage on en: level drops one edge after en is sampled low,
    // and a re-enabled held button presses DEBOUNCE_CYC+1 edges later.
    logic en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_CYC     (DEBOUNCE_CYC),
            .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
            .REPEAT_RATE_CYC  (REPEAT_RATE_CYC)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .en_i      (en_q),
            .raw_i     (btn_raw[i]),
            .level_o   (btn_level[i]),
            .press_o   (btn_press[i]),
            .release_o (btn_release[i]),
            .step_o    (btn_step[i])
        );
    end

endmodule

// File: tb/tb_paddle_btn_ctrl.sv
// Self-checking bench for paddle_btn_ctrl: directed scenarios plus random stimulus vs a model.
module tb_paddle_btn_ctrl;

    localparam int NB  = 4;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RR  = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_step;

    int n_cmp = 0;
    int n_err = 0;

    paddle_btn_ctrl #(
        .NUM_BTN          (NB),
        .DEBOUNCE_CYC     (DEB),
        .REPEAT_DELAY_CYC (RD),
        .REPEAT_RATE_CYC  (RR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_step    (btn_step)
    );

    always #5 clk = ~clk;

    // Reference model: run lengths of the synced level, time since (re)press.
    logic [NB-1:0] m_s1, m_s2;
    logic          m_en;
    bit            m_lvl [NB];
    int            m_high[NB];
    int            m_low [NB];
    int            m_hold[NB];
    logic [NB-1:0] exp_level, exp_press, exp_release, exp_step;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0;
        m_s2 = '0;
        m_en = 1'b0;
        for (int c = 0; c < NB; c++) begin
            m_lvl[c]  = 1'b0;
            m_high[c] = 0;
            m_low[c]  = 0;
            m_hold[c] = 0;
        end
        exp_level = '0; exp_press = '0; exp_release = '0; exp_step = '0;
    endtask

    task automatic model_edge();
        exp_press = '0; exp_release = '0; exp_step = '0;
        for (int c = 0; c < NB; c++) begin
            if (!m_en) begin
                m_lvl[c] = 1'b0; m_high[c] = 0; m_low[c] = 0; m_hold[c] = 0;
            end else if (!m_lvl[c]) begin
                if (m_s2[c]) begin
                    m_high[c]++;
                    if (m_high[c] == DEB + 1) begin
                        m_lvl[c] = 1'b1; m_high[c] = 0; m_hold[c] = 0;
                        exp_press[c] = 1'b1; exp_step[c] = 1'b1;
                    end
                end else begin
                    m_high[c] = 0;
                end
            end else begin
                if (!m_s2[c]) begin
                    m_low[c]++;
                    if (m_low[c] == DEB + 1) begin
                        m_lvl[c] = 1'b0; m_low[c] = 0; exp_release[c] = 1'b1;
                    end
                end else if (m_low[c] > 0) begin
                    m_low[c] = 0; m_hold[c] = 0;
                end else begin
                    m_hold[c]++;
                    if (m_hold[c] == RD || (m_hold[c] > RD && (m_hold[c] - RD) % RR == 0))
                        exp_step[c] = 1'b1;
                end
            end
            exp_level[c] = m_lvl[c];
        end
        m_s2 = m_s1;
        m_s1 = btn_raw;
        m_en = en;
    endtask

    task automatic check_outputs();
        chk("level", btn_level, exp_level);
        chk("press", btn_press, exp_press);
        chk("release", btn_release, exp_release);
        chk("step", btn_step, exp_step);
    endtask

    task automatic tick(input logic [NB-1:0] raw, input logic en_v);
        btn_raw = raw;
        en      = en_v;
        @(posedge clk);
        model_edge();
        #1 check_outputs();
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_outputs();
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    int p0, p3, r0, r3, cnt_a, cnt_b, last_step;
    logic lvl20, lvl21;
    logic [NB-1:0] rnd_raw;
    logic rnd_en;

    initial begin
        rst_n = 1'b0; en = 1'b0; btn_raw = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_outputs();
        #2 rst_n = 1'b1;
        repeat (3) tick('0, 1'b1);

        // Clean hold on bit 0.
        p0 = -1; r0 = -1; cnt_a = 0; last_step = -1;
        for (int e = 0; e < 46; e++) begin
            tick((e < 30) ? 4'b0001 : 4'b0000, 1'b1);
            if (btn_press[0]) p0 = e;
            if (btn_release[0]) r0 = e;
            if (btn_step[0]) begin cnt_a++; last_step = e; end
        end
        chk("hold_press_edge", p0, 6);
        chk("hold_release_edge", r0, 36);
        chk("hold_step_count", cnt_a, 7);
        chk("hold_last_step", last_step, 31);

        // Bounce on bit 1.
        cnt_a = 0;
        for (int e = 0; e < 15; e++) begin
            tick((e < 3) ? 4'b0010 : 4'b0000, 1'b1);
            cnt_a += int'(btn_level[1]) + int'(btn_press[1]) + int'(btn_step[1]);
        end
        chk("bounce_activity", cnt_a, 0);

        // Hold with a 2-edge glitch at edge 40.
        cnt_a = 0; last_step = -1;
        for (int e = 0; e < 72; e++) begin
            tick((e < 60 && e != 40 && e != 41) ? 4'b0001 : 4'b0000, 1'b1);
            if (e < 60 && btn_release[0]) cnt_a++;
            if (e > 44 && e < 60 && btn_step[0] && last_step < 0) last_step = e;
        end
        chk("glitch_release_count", cnt_a, 0);
        chk("glitch_next_step", last_step, 54);

        // Bits 0 and 3 together, bit 3 released 5 edges earlier.
        p0 = -1; p3 = -1; r0 = -1; r3 = -1; cnt_a = 0;
        for (int e = 0; e < 45; e++) begin
            tick({(e < 20), 2'b00, (e < 25)}, 1'b1);
            if (btn_press[0]) p0 = e;
            if (btn_press[3]) p3 = e;
            if (btn_release[0]) r0 = e;
            if (btn_release[3]) r3 = e;
            cnt_a += int'(btn_level[1]) + int'(btn_level[2]) + int'(btn_step[1]) + int'(btn_step[2]);
        end
        chk("dual_press0", p0, 6);
        chk("dual_press3", p3, 6);
        chk("dual_release_gap", r0 - r3, 5);
        chk("dual_crosstalk", cnt_a, 0);

        // Enable drop while bit 2 is held.
        p0 = -1; cnt_a = 0;
        for (int e = 0; e < 41; e++) begin
            tick(4'b0100, !(e >= 20 && e <= 24));
            if (e == 20) lvl20 = btn_level[2];
            if (e == 21) lvl21 = btn_level[2];
            if (e >= 20 && btn_release[2]) cnt_a++;
            if (e >= 25 && btn_press[2] && p0 < 0) p0 = e;
        end
        chk("en_level_at20", lvl20, 1'b1);
        chk("en_level_at21", lvl21, 1'b0);
        chk("en_release_count", cnt_a, 0);
        chk("en_repress_edge", p0, 30);
        repeat (12) tick('0, 1'b1);

        // Async reset mid-repeat on bit 1, button kept held.
        for (int e = 0; e < 30; e++) tick(4'b0010, 1'b1);
        reset_pulse();
        p0 = -1; cnt_b = 0;
        for (int e = 0; e < 12; e++) begin
            tick(4'b0010, 1'b1);
            if (btn_press[1] && p0 < 0) p0 = e;
            if (e < 6 && btn_release[1]) cnt_b++;
        end
        chk("rst_repress_edge", p0, 6);
        chk("rst_no_release", cnt_b, 0);
        repeat (12) tick('0, 1'b1);

        // Random stimulus with long-ish holds, enable drops and occasional resets.
        rnd_raw = '0; rnd_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NB; c++)
                if ($urandom_range(0, 14) == 0) rnd_raw[c] = ~rnd_raw[c];
            if (rnd_en ? ($urandom_range(0, 79) == 0) : ($urandom_range(0, 7) == 0))
                rnd_en = ~rnd_en;
            tick(rnd_raw, rnd_en);
            if ($urandom_range(0, 499) == 0) reset_pulse();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
